// File: rtl/compare_scan_controller_if.sv
// Bundles the scan request/result signals and the memory/comparator bus of the
// compare-scan controller into one interface.
interface compare_scan_controller_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              start;
  logic              mode;
  logic [DATA_W-1:0] key;
  logic [ADDR_W-1:0] baseAddr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memData;
  logic [DATA_W-1:0] cmpA;
  logic [DATA_W-1:0] cmpB;
  logic              cmpEqual;
  logic              busy;
  logic              done;
  logic              found;
  logic [ADDR_W-1:0] foundAddr;
  logic [ADDR_W:0]   matchCount;

  // Controller side: takes scan requests, owns the memory read port and comparator operands.
  modport slave (
    input  start, mode, key, baseAddr, count, memData, cmpEqual,
    output memAddr, cmpA, cmpB, busy, done, found, foundAddr, matchCount
  );

  // Requester / memory / comparator side.
  modport master (
    output start, mode, key, baseAddr, count, memData, cmpEqual,
    input  memAddr, cmpA, cmpB, busy, done, found, foundAddr, matchCount
  );
endinterface

// File: rtl/compare_scan_controller.sv
// Walks a window of data memory one address per cycle, drives the shared
// equality comparator and reports the first match or the total match count.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; results from the last scan are held
// ST_SCAN | one address per cycle, comparator result sampled each edge
// ST_DONE | one-cycle done pulse, results valid
module compare_scan_controller #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input logic                 clk,
  input logic                 reset,
  compare_scan_controller_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] MAX_COUNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_LEFT  = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic              found_q, found_d;
  logic [ADDR_W-1:0] found_addr_q, found_addr_d;
  logic [ADDR_W:0]   match_count_q, match_count_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      key_q         <= '0;
      mode_q        <= 1'b0;
      addr_q        <= '0;
      remaining_q   <= '0;
      found_q       <= 1'b0;
      found_addr_q  <= '0;
      match_count_q <= '0;
    end else begin
      state_q       <= state_d;
      key_q         <= key_d;
      mode_q        <= mode_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      found_q       <= found_d;
      found_addr_q  <= found_addr_d;
      match_count_q <= match_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    key_d         = key_q;
    mode_d        = mode_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    found_d       = found_q;
    found_addr_d  = found_addr_q;
    match_count_d = match_count_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          key_d         = bus.key;
          mode_d        = bus.mode;
          remaining_d   = bus.count;
          found_d       = 1'b0;
          found_addr_d  = '0;
          match_count_d = '0;
          if (bus.count == '0) begin
            // Empty window: memAddr is left untouched since nothing is read.
            state_d = ST_DONE;
          end else begin
            addr_d  = bus.baseAddr;
            state_d = ST_SCAN;
          end
        end
      end

      ST_SCAN: begin
        if (bus.cmpEqual) begin
          if (match_count_q != MAX_COUNT) begin
            match_count_d = match_count_q + 1'b1;
          end
          if (!found_q) begin
            found_d      = 1'b1;
            found_addr_d = addr_q;
          end
        end
        if ((remaining_q == ONE_LEFT) || (!mode_q && bus.cmpEqual)) begin
          state_d = ST_DONE;
        end else begin
          // Natural overflow of addr gives the modulo-depth wrap.
          addr_d      = addr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.memAddr    = addr_q;
  assign bus.cmpA       = key_q;
  assign bus.cmpB       = bus.memData;
  assign bus.busy       = (state_q == ST_SCAN);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.found      = found_q;
  assign bus.foundAddr  = found_addr_q;
  assign bus.matchCount = match_count_q;

endmodule

// File: doc/compare_scan_controller.md
Name: compare_scan_controller

Overview:
- Sequences the shared 8-bit equality comparator to search a window of data memory for a key byte.
- Walks memory one address per cycle and drives the comparator operands.
- Samples the comparator's equal result and reports either the first match or the total match count.
- Sits beside the data memory; the memory read port and the comparator are time-shared with it while busy is high.

Parameters:
- ADDR_W, 4, address width; memory depth is 2^ADDR_W.
- DATA_W, 8, data/key width; must equal the comparator operand width.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, request a scan; sampled only in IDLE.
- mode, input, 1, 0 = stop at first match, 1 = count all matches; latched at start.
- key, input, DATA_W, value searched for; latched at start.
- baseAddr, input, ADDR_W, first address scanned; latched at start.
- count, input, ADDR_W+1, number of addresses to scan (0..2^ADDR_W); latched at start.
- memAddr, output, ADDR_W, read address to data memory (combinational-read memory).
- memData, input, DATA_W, read data for memAddr, same cycle.
- cmpA, output, DATA_W, comparator operand A = latched key.
- cmpB, output, DATA_W, comparator operand B = memData passthrough.
- cmpEqual, input, 1, comparator result for cmpA/cmpB.
- busy, output, 1, high in SCAN.
- done, output, 1, one-cycle pulse when results are valid.
- found, output, 1, at least one match in the scanned window.
- foundAddr, output, ADDR_W, address of first match (mode 0 and mode 1).
- matchCount, output, ADDR_W+1, number of matches (mode 1; in mode 0 it is 0 or 1).

Behaviour:
- FSM states are IDLE, SCAN and DONE.
- Reset:
  - State goes to IDLE.
  - busy=0, done=0, found=0, foundAddr=0, matchCount=0, memAddr=0.
  - Internal key, mode, index and remaining count are cleared.
  - Reset mid-scan aborts immediately: no done pulse, and results are cleared.
- IDLE:
  - memAddr holds its last value and cmpA holds the latched key.
  - On an edge with start=1, latch key, mode, baseAddr and count.
  - On the same edge, clear found, foundAddr and matchCount.
  - If count=0, go to DONE (no memory access). Otherwise go to SCAN with addr=baseAddr and remaining=count.
- SCAN (one address per cycle):
  - memAddr = current addr; cmpB = memData; cmpA = key.
  - At each edge, if cmpEqual=1:
    - matchCount increments.
    - If found was 0, set found=1 and foundAddr=addr.
  - Termination: go to DONE when remaining==1, or when mode=0 and cmpEqual=1. Otherwise addr=addr+1 and remaining=remaining-1.
- Address arithmetic is modulo 2^ADDR_W: wraps from 2^ADDR_W-1 to 0.
  - count=2^ADDR_W scans every address exactly once.
  - A wrapped address never double-counts.
- DONE:
  - done=1 for exactly one cycle, then return to IDLE.
  - found, foundAddr and matchCount hold their values until the next accepted start or reset.
- Latency:
  - Full scan of N>0 addresses: done is high N+1 cycles after the start edge (N SCAN cycles + 1 DONE cycle).
  - Mode 0 with a match at window offset i: done is high i+2 cycles after the start edge.
  - count=0: done is high 1 cycle after the start edge.
- start during SCAN or DONE is ignored; it is not queued.
- start held high continuously restarts a scan on each IDLE visit, so back-to-back scans have a 1-cycle IDLE gap minimum.
- Inputs key, mode, baseAddr and count may change freely after the start edge without affecting an ongoing scan.
- cmpEqual is only acted on in SCAN; it is ignored in IDLE and DONE.
- matchCount saturates at 2^ADDR_W. This cannot be exceeded by construction, but must not wrap.

Test Plan:
- Memory filled with mem[a]=a*3; start mode=0, key=0x0F, base=0, count=16 -> match at addr 5; done 7 cycles after start; found=1, foundAddr=5, matchCount=1.
- Memory all 0xAA except mem[2]=mem[9]=mem[14]=0x55; mode=1, key=0x55, base=0, count=16 -> done 17 cycles after start; found=1, foundAddr=2, matchCount=3.
- Wrap: mem[1]=0x7E only; mode=0, key=0x7E, base=14, count=4 -> scans 14,15,0,1; foundAddr=1, done 5 cycles after start. Repeat with count=3 -> found=0, matchCount=0, done 4 cycles after start.
- count=0 -> done exactly 1 cycle after start, busy never asserted, found=0. Key absent with count=16 -> found=0 after 17 cycles.
- Assert reset at 4th SCAN cycle -> next cycle busy=0, found=0, matchCount=0, no done pulse. A new start then behaves normally.
- Pulse start again mid-scan with a different key -> ignored; the result reflects the original key. Start held high -> second scan begins after one IDLE cycle, and results are cleared on its start edge.
